// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl
// Consumer-side controller for a PS/2 keyboard receiver FIFO. Pops scan-code
// bytes through the ready/nextdata_n handshake, tracks the E0 (extended) and
// F0 (break) prefixes, keeps shift / caps-lock / held-key state, and emits one
// decoded key event per make code over a valid/ready channel.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   kb_data           scan code at the FIFO head (valid while kb_ready)
//   kb_ready          FIFO non-empty
//   kb_overflow       FIFO overflow flag
//   kb_nextdata_n     active-low pop strobe, one cycle per consumed byte
//   ev_valid/ev_ready key event handshake
//   ev_code           make code without prefix
//   ev_ascii          translated character, 0x00 if unmapped
//   ev_ext            event was E0-prefixed
//   ev_repeat         event is a typematic repeat of the held key
//   caps_on, shift_on modifier state
//   char_count        accepted events with nonzero ascii, wraps
//   err_overflow      sticky overflow flag
module ps2_key_ctrl #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic [7:0]       ev_ascii,
    output logic             ev_ext,
    output logic             ev_repeat,
    output logic             caps_on,
    output logic             shift_on,
    output logic [CNT_W-1:0] char_count,
    output logic             err_overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_SETTLE,
        S_DECODE
    } state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LSHF  = 8'h12;
    localparam logic [7:0] SC_RSHF  = 8'h59;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_CAPS  = 8'h58;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic             shl_q, shl_d;
    logic             shr_q, shr_d;
    logic             caps_q, caps_d;
    logic             held_v_q, held_v_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic             ev_valid_q, ev_valid_d;
    logic [7:0]       ev_code_q, ev_code_d;
    logic [7:0]       ev_ascii_q, ev_ascii_d;
    logic             ev_ext_q, ev_ext_d;
    logic             ev_rep_q, ev_rep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             xfer;
    logic             held_hit;

    // Unshifted ASCII for a non-extended make code; letters are returned in
    // lowercase and folded to uppercase when 'upper' is set.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] c;
        logic       letter;
        c      = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
            8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
            8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
            8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
            8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
            8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
            8'h35: c = "y";  8'h1A: c = "z";
            default: begin
                letter = 1'b0;
                case (code)
                    8'h45: c = "0";  8'h16: c = "1";  8'h1E: c = "2";  8'h26: c = "3";
                    8'h25: c = "4";  8'h2E: c = "5";  8'h36: c = "6";  8'h3D: c = "7";
                    8'h3E: c = "8";  8'h46: c = "9";
                    8'h29: c = 8'h20;
                    8'h5A: c = 8'h0D;
                    8'h66: c = 8'h08;
                    default: c = 8'h00;
                endcase
            end
        endcase
        if (letter && upper) begin
            c = c - 8'h20;
        end
        return c;
    endfunction

    assign xfer     = ev_valid_q & ev_ready;
    // Held-key match against the byte being decoded and the current prefix.
    assign held_hit = held_v_q && (held_code_q == byte_q) && (held_ext_q == ext_q);

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        nextdata_n_d = nextdata_n_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        shl_d        = shl_q;
        shr_d        = shr_q;
        caps_d       = caps_q;
        held_v_d     = held_v_q;
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        ev_valid_d   = ev_valid_q;
        ev_code_d    = ev_code_q;
        ev_ascii_d   = ev_ascii_q;
        ev_ext_d     = ev_ext_q;
        ev_rep_d     = ev_rep_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q | kb_overflow;

        if (xfer) begin
            ev_valid_d = 1'b0;
            if (ev_ascii_q != 8'h00) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                // Fetch only when the event slot is free (or draining now), so
                // back-pressure leaves further bytes in the receiver FIFO.
                if (kb_ready && (!ev_valid_q || ev_ready)) begin
                    byte_d       = kb_data;
                    nextdata_n_d = 1'b0;
                    state_d      = S_POP;
                end
            end
            S_POP: begin
                nextdata_n_d = 1'b1;
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (byte_q == SC_EXT) begin
                    ext_d = 1'b1;
                end else if (byte_q == SC_BRK) begin
                    brk_d = 1'b1;
                end else if (brk_q) begin
                    if (byte_q == SC_LSHF) shl_d = 1'b0;
                    if (byte_q == SC_RSHF) shr_d = 1'b0;
                    if (held_hit) held_v_d = 1'b0;
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else if (!ext_q && (byte_q == SC_LSHF || byte_q == SC_RSHF ||
                                        byte_q == SC_CTRL)) begin
                    if (byte_q == SC_LSHF) shl_d = 1'b1;
                    if (byte_q == SC_RSHF) shr_d = 1'b1;
                    ext_d = 1'b0;
                end else if (!ext_q && byte_q == SC_CAPS) begin
                    // Auto-repeat of a held caps key must not keep toggling.
                    if (!held_hit) caps_d = ~caps_q;
                    held_v_d    = 1'b1;
                    held_code_d = byte_q;
                    held_ext_d  = 1'b0;
                    ext_d       = 1'b0;
                end else begin
                    ev_valid_d  = 1'b1;
                    ev_code_d   = byte_q;
                    ev_ascii_d  = ext_q ? 8'h00
                                        : scan_to_ascii(byte_q, (shl_q | shr_q) ^ caps_q);
                    ev_ext_d    = ext_q;
                    ev_rep_d    = held_hit;
                    held_v_d    = 1'b1;
                    held_code_d = byte_q;
                    held_ext_d  = ext_q;
                    ext_d       = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_q       <= 8'h00;
            nextdata_n_q <= 1'b1;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            shl_q        <= 1'b0;
            shr_q        <= 1'b0;
            caps_q       <= 1'b0;
            held_v_q     <= 1'b0;
            held_code_q  <= 8'h00;
            held_ext_q   <= 1'b0;
            ev_valid_q   <= 1'b0;
            ev_code_q    <= 8'h00;
            ev_ascii_q   <= 8'h00;
            ev_ext_q     <= 1'b0;
            ev_rep_q     <= 1'b0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            nextdata_n_q <= nextdata_n_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            shl_q        <= shl_d;
            shr_q        <= shr_d;
            caps_q       <= caps_d;
            held_v_q     <= held_v_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            ev_valid_q   <= ev_valid_d;
            ev_code_q    <= ev_code_d;
            ev_ascii_q   <= ev_ascii_d;
            ev_ext_q     <= ev_ext_d;
            ev_rep_q     <= ev_rep_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign kb_nextdata_n = nextdata_n_q;
    assign ev_valid      = ev_valid_q;
    assign ev_code       = ev_code_q;
    assign ev_ascii      = ev_ascii_q;
    assign ev_ext        = ev_ext_q;
    assign ev_repeat     = ev_rep_q;
    assign caps_on       = caps_q;
    assign shift_on      = shl_q | shr_q;
    assign char_count    = cnt_q;
    assign err_overflow  = ovf_q;

endmodule
